h_bridge_driver: RTL and testbench
==================================

// Module: h_bridge_driver
//
// PURPOSE
//   Output stage downstream of a pwm_channel. Converts the raw PWM waveform
//   plus a drive command into the three H-bridge pins (pwm_signal,
//   H_bridge_1, H_bridge_2). Inserts a programmable dead-time on every
//   transition between actively-driven bridge states, so both high-side and
//   low-side legs are never switched in the same edge. Provides a saturating
//   count of dead-time events for diagnostics.
//
// PARAMETERS
//   DEAD_TIME    50   dead-time length in clk cycles (1 us at 50 MHz); legal range 1..65535
//   CNT_WIDTH    16   width of the dead_events counter
//
// PORTS
//   clk          in   1          system clock (CLOCK_50)
//   reset        in   1          synchronous, active-low reset
//   enable       in   1          0 forces COAST command
//   mode         in   2          00 COAST, 01 FORWARD, 10 REVERSE, 11 BRAKE
//   pwm_in       in   1          raw PWM from pwm generator
//   pwm_signal   out  1          bridge enable/PWM pin
//   H_bridge_1   out  1          bridge input 1
//   H_bridge_2   out  1          bridge input 2
//   busy         out  1          high while in DEAD state
//   dead_events  out  CNT_WIDTH  saturating count of DEAD entries
//
// BEHAVIOUR
//   - Command: cmd = enable ? mode : COAST, evaluated every cycle.
//   - States and registered outputs {pwm_signal, H_bridge_1, H_bridge_2}:
//       COAST {0,0,0}; FWD {pwm_in,1,0}; REV {pwm_in,0,1};
//       BRAKE {1,1,1}; DEAD {0,0,0}.
//   - All outputs are registered. A pwm_in edge reaches pwm_signal 1 clk later.
//   - Reset (reset==0 on a clk edge):
//       state = COAST, all outputs 0, busy 0, dead_events 0, counter 0.
//     This applies from any state, including mid-DEAD.
//   - Transitions:
//       COAST -> FWD/REV/BRAKE: direct, next cycle (bridge already off).
//       any -> COAST: direct, next cycle; dead-time is not required.
//       FWD/REV/BRAKE -> different active cmd: enter DEAD.
//         On entry: load counter = DEAD_TIME-1, latch target = cmd,
//         and increment dead_events (saturate at all-ones).
//       Active state with cmd unchanged: hold.
//   - DEAD:
//       - counter decrements each cycle.
//       - target re-latched from cmd every cycle while in DEAD.
//       - cmd == COAST in DEAD: exit to COAST next cycle; remaining count is abandoned.
//       - counter == 0: go to target next cycle. The full dead-time is
//         completed even if target equals the state originally left.
//       - Total zero-output time on a change = DEAD_TIME cycles exactly.
//   - busy = (state == DEAD), registered with state.
//   - BRAKE ignores pwm_in.
//   - In FWD/REV, a pwm_in glitch passes through; it is not filtered.
//
// TESTING  (DEAD_TIME=4)
//   1. reset low 3 cycles, then high with mode=01, enable=1 ->
//      outputs 0 during reset; next cycle H1=1, H2=0, pwm_signal tracks
//      pwm_in delayed 1 cycle.
//   2. In FWD, mode 01->10 ->
//      exactly 4 cycles of {0,0,0} with busy=1, then {pwm_in,0,1};
//      dead_events = 1.
//   3. In DEAD after 2 cycles, mode -> 00 ->
//      COAST next cycle, busy=0; no REV drive ever asserted.
//   4. FWD -> BRAKE -> REV ->
//      two DEAD windows of 4 cycles each; BRAKE outputs {1,1,1};
//      dead_events = 2.
//   5. enable=0 while in REV ->
//      COAST next cycle with no DEAD. Then enable=1 with mode=10 ->
//      REV next cycle.
//   6. Force 0xFFFE dead events ->
//      counter saturates at 0xFFFF and never wraps.
//      Also assert reset mid-DEAD: all outputs 0 next cycle.

Source files
------------

// File: rtl/h_bridge_driver.sv
// H-bridge output stage: maps a drive command and a raw PWM waveform onto the
// three bridge pins, inserting a dead-time between actively driven states.
module h_bridge_driver #(
  parameter int DEAD_TIME = 50,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [1:0]           mode,
  input  logic                 pwm_in,
  output logic                 pwm_signal,
  output logic                 H_bridge_1,
  output logic                 H_bridge_2,
  output logic                 busy,
  output logic [CNT_WIDTH-1:0] dead_events
);

  typedef enum logic [2:0] {
    S_COAST,
    S_FWD,
    S_REV,
    S_BRAKE,
    S_DEAD
  } state_t;

  localparam logic [15:0] DEAD_LOAD = 16'(DEAD_TIME - 1);

  state_t      state, next_state;
  state_t      target, next_target;
  logic [15:0] count, next_count;
  logic        enter_dead;
  logic [1:0]  cmd;
  state_t      cmd_st;
  logic [2:0]  next_out;

  function automatic state_t cmd_to_state(input logic [1:0] c);
    case (c)
      2'b01:   return S_FWD;
      2'b10:   return S_REV;
      2'b11:   return S_BRAKE;
      default: return S_COAST;
    endcase
  endfunction

  assign cmd    = enable ? mode : 2'b00;
  assign cmd_st = cmd_to_state(cmd);

  always_comb begin
    next_state  = state;
    next_count  = count;
    next_target = target;
    enter_dead  = 1'b0;
    case (state)
      S_COAST: next_state = cmd_st;
      S_FWD, S_REV, S_BRAKE: begin
        if (cmd_st == S_COAST) begin
          next_state = S_COAST;
        end else if (cmd_st != state) begin
          next_state  = S_DEAD;
          next_count  = DEAD_LOAD;
          next_target = cmd_st;
          enter_dead  = 1'b1;
        end
      end
      S_DEAD: begin
        // Target follows the command; the window still runs to completion.
        next_target = cmd_st;
        if (cmd_st == S_COAST) begin
          next_state = S_COAST;
          next_count = '0;
        end else if (count == 16'd0) begin
          next_state = target;
        end else begin
          next_count = count - 16'd1;
        end
      end
      default: next_state = S_COAST;
    endcase
  end

  // Outputs are precomputed from next_state so they register with the state.
  always_comb begin
    next_out = 3'b000;
    case (next_state)
      S_FWD:   next_out = {pwm_in, 1'b1, 1'b0};
      S_REV:   next_out = {pwm_in, 1'b0, 1'b1};
      S_BRAKE: next_out = 3'b111;
      default: next_out = 3'b000;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= S_COAST;
      target      <= S_COAST;
      count       <= '0;
      pwm_signal  <= 1'b0;
      H_bridge_1  <= 1'b0;
      H_bridge_2  <= 1'b0;
      busy        <= 1'b0;
      dead_events <= '0;
    end else begin
      state  <= next_state;
      target <= next_target;
      count  <= next_count;
      {pwm_signal, H_bridge_1, H_bridge_2} <= next_out;
      busy   <= (next_state == S_DEAD);
      if (enter_dead && (dead_events != {CNT_WIDTH{1'b1}}))
        dead_events <= dead_events + 1'b1;
    end
  end

endmodule

// File: tb/tb_h_bridge_driver.sv
// Self-checking bench for h_bridge_driver against a cycle-level behavioural
// model of the command/dead-time rules.
module tb_h_bridge_driver;

  localparam int DT    = 4;
  // Narrow counter keeps saturation reachable in a short run.
  localparam int CNT_W = 6;
  localparam int EVMAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             reset;
  logic             enable;
  logic [1:0]       mode;
  logic             pwm_in;
  logic             pwm_signal, H_bridge_1, H_bridge_2, busy;
  logic [CNT_W-1:0] dead_events;

  int total = 0;
  int bad   = 0;

  // Model: st uses command coding (0 coast,1 fwd,2 rev,3 brake), 4 = dead.
  int m_st  = 0;
  int m_rem = 0;
  int m_tgt = 0;
  int m_ev  = 0;
  logic [2:0]       exp_out = 3'b000;
  logic             exp_busy = 1'b0;
  logic [CNT_W-1:0] exp_ev = '0;

  h_bridge_driver #(.DEAD_TIME(DT), .CNT_WIDTH(CNT_W)) dut (
    .clk(clk), .reset(reset), .enable(enable), .mode(mode), .pwm_in(pwm_in),
    .pwm_signal(pwm_signal), .H_bridge_1(H_bridge_1), .H_bridge_2(H_bridge_2),
    .busy(busy), .dead_events(dead_events)
  );

  always #5 clk = ~clk;

  task automatic model_step();
    int cmd;
    cmd = enable ? int'(mode) : 0;
    if (!reset) begin
      m_st = 0; m_rem = 0; m_tgt = 0; m_ev = 0;
    end else if (m_st == 4) begin
      if (cmd == 0) m_st = 0;
      else if (m_rem == 1) m_st = m_tgt;
      else m_rem = m_rem - 1;
      m_tgt = cmd;
    end else if (cmd == 0) begin
      m_st = 0;
    end else if (m_st == 0) begin
      m_st = cmd;
    end else if (cmd != m_st) begin
      m_st = 4; m_rem = DT; m_tgt = cmd;
      if (m_ev < EVMAX) m_ev = m_ev + 1;
    end
    case (m_st)
      1:       exp_out = {pwm_in, 1'b1, 1'b0};
      2:       exp_out = {pwm_in, 1'b0, 1'b1};
      3:       exp_out = 3'b111;
      default: exp_out = 3'b000;
    endcase
    exp_busy = (m_st == 4);
    exp_ev   = CNT_W'(m_ev);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; enable = 1'b1; mode = 2'b01; pwm_in = 1'b1;
    repeat (3) begin
      tick();
      total++;
      if ({pwm_signal, H_bridge_1, H_bridge_2, busy, dead_events} !== '0) begin
        bad++;
        $display("[TB] FAIL reset_zero got=%b%b%b busy=%b ev=%0d want=0", pwm_signal, H_bridge_1, H_bridge_2, busy, dead_events);
      end
    end
    reset = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      total++;
      if ({pwm_signal, H_bridge_1, H_bridge_2, busy} !== {exp_out, exp_busy}) begin
        bad++;
        $display("[TB] FAIL fwd_track got=%b%b%b busy=%b want=%b busy=%b", pwm_signal, H_bridge_1, H_bridge_2, busy, exp_out, exp_busy);
      end
      pwm_in = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic test_fwd_to_rev();
    int busy_cycles = 0;
    mode = 2'b10;
    for (int i = 0; i < DT; i++) begin
      tick();
      pwm_in = 1'($urandom_range(0, 1));
      if (busy === 1'b1 && {pwm_signal, H_bridge_1, H_bridge_2} === 3'b000) busy_cycles++;
    end
    total++;
    if (busy_cycles !== DT) begin
      bad++;
      $display("[TB] FAIL dead_len got=%0d want=%0d", busy_cycles, DT);
    end
    tick();
    total++;
    if ({pwm_signal, H_bridge_1, H_bridge_2, busy} !== {exp_out, exp_busy} || H_bridge_2 !== 1'b1) begin
      bad++;
      $display("[TB] FAIL rev_entry got=%b%b%b busy=%b want=%b busy=%b", pwm_signal, H_bridge_1, H_bridge_2, busy, exp_out, exp_busy);
    end
    total++;
    if (dead_events !== exp_ev || dead_events !== CNT_W'(1)) begin
      bad++;
      $display("[TB] FAIL events_one got=%0d want=1", dead_events);
    end
  endtask

  task automatic test_dead_abort();
    logic saw_rev = 1'b0;
    mode = 2'b01;
    repeat (DT + 1) tick();
    total++;
    if ({pwm_signal, H_bridge_1, H_bridge_2, busy} !== {exp_out, exp_busy}) begin
      bad++;
      $display("[TB] FAIL back_fwd got=%b%b%b busy=%b want=%b busy=%b", pwm_signal, H_bridge_1, H_bridge_2, busy, exp_out, exp_busy);
    end
    mode = 2'b10;
    repeat (2) begin
      tick();
      if (H_bridge_2 === 1'b1) saw_rev = 1'b1;
    end
    mode = 2'b00;
    tick();
    total++;
    if ({pwm_signal, H_bridge_1, H_bridge_2, busy} !== 4'b0000 || exp_busy !== 1'b0) begin
      bad++;
      $display("[TB] FAIL abort_coast got=%b%b%b busy=%b want=0000", pwm_signal, H_bridge_1, H_bridge_2, busy);
    end
    repeat (DT + 2) begin
      tick();
      if (H_bridge_2 === 1'b1) saw_rev = 1'b1;
    end
    total++;
    if (saw_rev !== 1'b0) begin
      bad++;
      $display("[TB] FAIL abort_no_rev got=%b want=0", saw_rev);
    end
  endtask

  task automatic test_brake_chain();
    int ev0;
    mode = 2'b01;
    tick();
    ev0 = int'(dead_events);
    mode = 2'b11;
    for (int i = 0; i < DT + 3; i++) begin
      tick();
      pwm_in = ~pwm_in;
      total++;
      if ({pwm_signal, H_bridge_1, H_bridge_2, busy} !== {exp_out, exp_busy}) begin
        bad++;
        $display("[TB] FAIL brake_seq cyc=%0d got=%b%b%b busy=%b want=%b busy=%b", i, pwm_signal, H_bridge_1, H_bridge_2, busy, exp_out, exp_busy);
      end
    end
    total++;
    if ({pwm_signal, H_bridge_1, H_bridge_2} !== 3'b111) begin
      bad++;
      $display("[TB] FAIL brake_out got=%b%b%b want=111", pwm_signal, H_bridge_1, H_bridge_2);
    end
    mode = 2'b10;
    repeat (DT + 1) tick();
    total++;
    if ({H_bridge_1, H_bridge_2, busy} !== 3'b010 || int'(dead_events) - ev0 !== 2) begin
      bad++;
      $display("[TB] FAIL brake_rev got=%b%b busy=%b ev_delta=%0d want=01 busy=0 ev_delta=2", H_bridge_1, H_bridge_2, busy, int'(dead_events) - ev0);
    end
  endtask

  task automatic test_enable_coast();
    enable = 1'b0;
    tick();
    total++;
    if ({pwm_signal, H_bridge_1, H_bridge_2, busy} !== 4'b0000) begin
      bad++;
      $display("[TB] FAIL en_coast got=%b%b%b busy=%b want=0000", pwm_signal, H_bridge_1, H_bridge_2, busy);
    end
    enable = 1'b1; mode = 2'b10;
    tick();
    total++;
    if ({pwm_signal, H_bridge_1, H_bridge_2, busy} !== {exp_out, exp_busy} || {H_bridge_1, H_bridge_2} !== 2'b01) begin
      bad++;
      $display("[TB] FAIL en_rev got=%b%b%b busy=%b want=%b busy=%b", pwm_signal, H_bridge_1, H_bridge_2, busy, exp_out, exp_busy);
    end
  endtask

  task automatic test_saturation();
    reset = 1'b0; tick(); reset = 1'b1;
    for (int k = 0; k < EVMAX + 6; k++) begin
      mode = (k % 2 == 0) ? 2'b01 : 2'b10;
      repeat (DT + 2) begin
        tick();
        total++;
        if (dead_events !== exp_ev || busy !== exp_busy) begin
          bad++;
          $display("[TB] FAIL sat_track got=%0d busy=%b want=%0d busy=%b", dead_events, busy, exp_ev, exp_busy);
        end
      end
    end
    total++;
    if (dead_events !== {CNT_W{1'b1}}) begin
      bad++;
      $display("[TB] FAIL sat_value got=%0d want=%0d", dead_events, EVMAX);
    end
    mode = ~mode;
    repeat (2) tick();
    reset = 1'b0;
    tick();
    total++;
    if ({pwm_signal, H_bridge_1, H_bridge_2, busy, dead_events} !== '0) begin
      bad++;
      $display("[TB] FAIL reset_mid_dead got=%b%b%b busy=%b ev=%0d want=0", pwm_signal, H_bridge_1, H_bridge_2, busy, dead_events);
    end
    reset = 1'b1;
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) == 0) mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 15) == 0) enable = ~enable;
      reset  = ($urandom_range(0, 99) == 0) ? 1'b0 : 1'b1;
      pwm_in = 1'($urandom_range(0, 1));
      tick();
      total++;
      if ({pwm_signal, H_bridge_1, H_bridge_2, busy, dead_events} !== {exp_out, exp_busy, exp_ev}) begin
        bad++;
        $display("[TB] FAIL random cyc=%0d got=%b%b%b busy=%b ev=%0d want=%b busy=%b ev=%0d", i, pwm_signal, H_bridge_1, H_bridge_2, busy, dead_events, exp_out, exp_busy, exp_ev);
      end
    end
  endtask

  initial begin
    reset = 1'b0; enable = 1'b0; mode = 2'b00; pwm_in = 1'b0;
    test_reset();
    test_fwd_to_rev();
    test_dead_abort();
    test_brake_chain();
    test_enable_coast();
    test_saturation();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
